// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller driving a single-port synchronous RAM.
// Reads take priority over writes on the shared RAM port. The head word is
// fetched into a registered PopData/PopValid output stage.
// Optional feature: define RAM_FIFO_CTRL_CLEAR_EN to add a synchronous Clear
// input that flushes the FIFO contents while retaining PopData.
module ram_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  Clk,
   input  logic                  Reset,
`ifdef RAM_FIFO_CTRL_CLEAR_EN
   input  logic                  Clear,
`endif
   input  logic                  PushValid,
   output logic                  PushReady,
   input  logic [DATA_WIDTH-1:0] PushData,
   output logic                  PopValid,
   input  logic                  PopReady,
   output logic [DATA_WIDTH-1:0] PopData,
   output logic [ADDR_WIDTH:0]   Count,
   output logic                  Full,
   output logic                  Empty,
   output logic [ADDR_WIDTH-1:0] RamAddr,
   output logic                  RamWrite,
   output logic [DATA_WIDTH-1:0] RamInput,
   input  logic [DATA_WIDTH-1:0] RamOutput
);

   localparam int COUNT_W = ADDR_WIDTH + 1;
   localparam int DEPTH   = 1 << ADDR_WIDTH;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t              state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [COUNT_W-1:0]    mem_count;
   logic                  flush;
   logic                  rd_issue;
   logic                  push_fire;
   logic                  pop_fire;

`ifdef RAM_FIFO_CTRL_CLEAR_EN
   assign flush = Reset || Clear;
`else
   assign flush = Reset;
`endif

   // A RAM read is started whenever the output stage is (or is about to be) free.
   assign rd_issue  = (state == IDLE) && (mem_count != '0) && (!PopValid || PopReady) && !flush;
   assign PushReady = !Full && !rd_issue && !flush;
   assign push_fire = PushValid && PushReady;
   assign pop_fire  = PopValid && PopReady;

   // Status flags derived from registered state only.
   assign Full  = (mem_count == COUNT_W'(DEPTH));
   assign Count = mem_count + COUNT_W'(state == FETCH) + COUNT_W'(PopValid);
   assign Empty = (Count == '0);

   // RAM port steering: the read address wins in an issue cycle, otherwise the write address.
   always_comb begin
      RamWrite = push_fire;
      RamInput = PushData;
      RamAddr  = wr_ptr;
      if (rd_issue) begin
         RamAddr = rd_ptr;
      end
   end

   // Pointer, occupancy, fetch state and output register updates.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
         state     <= IDLE;
         PopValid  <= 1'b0;
         PopData   <= '0;
`ifdef RAM_FIFO_CTRL_CLEAR_EN
      end else if (Clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
         state     <= IDLE;
         PopValid  <= 1'b0;
`endif
      end else begin
         if (push_fire) begin
            wr_ptr    <= wr_ptr + ADDR_WIDTH'(1);
            mem_count <= mem_count + COUNT_W'(1);
         end else if (rd_issue) begin
            mem_count <= mem_count - COUNT_W'(1);
         end

         if (rd_issue) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end

         case (state)
            IDLE: begin
               if (rd_issue) begin
                  state <= FETCH;
               end
               if (pop_fire) begin
                  PopValid <= 1'b0;
               end
            end
            FETCH: begin
               PopData  <= RamOutput;
               PopValid <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
